// File: rtl/key_pkg.sv
// Shared FSM encoding, default timings and counter-width helper for the push-button conditioner.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } key_state_e;

  // 20 ms debounce, 1 s long-press, 200 ms repeat at 50 MHz
  localparam int DEF_DEBOUNCE_CYC = 1000000;
  localparam int DEF_LONG_CYC     = 50000000;
  localparam int DEF_REPEAT_CYC   = 10000000;

  function automatic int cnt_w(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/key_chan.sv
// One key: 2-flop sync, debounce, IDLE/HELD/LONG FSM, hold/repeat counters; repeat only with KEY_AUTOREPEAT_EN.
// Latency: press/release seen 2+DEBOUNCE_CYC cycles after the pin settles; no backpressure, pulses are fire-and-forget.
module key_chan
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pressed,
  output logic press_pulse,
  output logic long_pulse,
  output logic release_pulse
);

  localparam int DW = cnt_w(DEBOUNCE_CYC);
  localparam int HW = cnt_w(LONG_CYC);

  if (DEBOUNCE_CYC < 1 || LONG_CYC <= DEBOUNCE_CYC || REPEAT_CYC < 1) begin : g_bad_params
    $error("key_chan: illegal timing parameters");
  end

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_nxt;
  key_state_e    state;
  key_state_e    state_nxt;
  logic          differ;
  logic          db_done;
  logic          rise;
  logic          fall;
  logic          long_hit;
  logic          rep_hit;
  logic          pp_d;
  logic          lp_d;
  logic          rp_d;

  // Pin is active-low; flops idle at 1 so reset looks like "released"
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign differ  = (~sync2) ^ pressed;
  assign db_done = differ && (db_cnt == DW'(DEBOUNCE_CYC - 1));
  assign rise    = db_done && !pressed;
  assign fall    = db_done && pressed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt  <= '0;
      pressed <= 1'b0;
    end else begin
      if (!differ || db_done) db_cnt <= '0;
      else                    db_cnt <= db_cnt + DW'(1);
      if (db_done) pressed <= ~pressed;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (rise) state_nxt = HELD;
      HELD:    if (fall) state_nxt = IDLE;
               else if (long_hit) state_nxt = LONG;
      LONG:    if (fall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Hold count reads 1 in the first pressed cycle, so LONG_CYC is reached on that cycle's count
  assign long_hit = (state == HELD) && !fall && (hold_cnt == HW'(LONG_CYC - 1));

  always_comb begin
    hold_nxt = hold_cnt;
    if (rise)                            hold_nxt = HW'(1);
    else if (fall || state == IDLE)      hold_nxt = '0;
    else if (hold_cnt != HW'(LONG_CYC))  hold_nxt = hold_cnt + HW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_cnt <= '0;
    else     hold_cnt <= hold_nxt;
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = cnt_w(REPEAT_CYC);
  logic [RW-1:0] rep_cnt;

  assign rep_hit = (state == LONG) && !fall && (rep_cnt == RW'(REPEAT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  rep_cnt <= '0;
    else if (state != LONG || fall || rep_hit) rep_cnt <= '0;
    else                                       rep_cnt <= rep_cnt + RW'(1);
  end
`else
  assign rep_hit = 1'b0;
`endif

  always_comb begin
    pp_d = rise | rep_hit;
    lp_d = long_hit;
    rp_d = fall;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= pp_d;
      long_pulse    <= lp_d;
      release_pulse <= rp_d;
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Two independent push-button channels (sync, debounce, press/long/release pulses); auto-repeat with KEY_AUTOREPEAT_EN.
// Latency: outputs registered, 2+DEBOUNCE_CYC cycles after a settled pin edge; no backpressure.
module key_conditioner
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] KEY,
  output logic [1:0] pressed,
  output logic [1:0] press_pulse,
  output logic [1:0] long_pulse,
  output logic [1:0] release_pulse
);

  for (genvar i = 0; i < 2; i++) begin : g_key
    key_chan #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .REPEAT_CYC   (REPEAT_CYC)
    ) u_chan (
      .clk           (clk),
      .rst           (rst),
      .key_n         (KEY[i]),
      .pressed       (pressed[i]),
      .press_pulse   (press_pulse[i]),
      .long_pulse    (long_pulse[i]),
      .release_pulse (release_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus random key/reset traffic against a cycle-history model.
module tb_key_conditioner;

  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 5;
  localparam int N = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] KEY = 2'b11;
  logic [1:0] pressed, press_pulse, long_pulse, release_pulse;

  key_conditioner #(
    .DEBOUNCE_CYC (D),
    .LONG_CYC     (L),
    .REPEAT_CYC   (R)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .KEY           (KEY),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .long_pulse    (long_pulse),
    .release_pulse (release_pulse)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int base  = 0;

  logic [1:0] raw_h [N];
  bit         rst_h [N];
  bit   [1:0] mp    [N];
  int         rise_c [2];
  int         long_c [2];
  logic [1:0] key_drv = 2'b11;
  logic       rst_drv = 1'b1;
  logic [1:0] e_pr, e_pp, e_lp, e_rp;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Held level (1 = pressed) seen after the 2-cycle synchronizer at cycle x
  function automatic bit lvl(input int x, input int i);
    if (x < 2) return 1'b0;
    if (rst_h[x-1] || rst_h[x-2]) return 1'b0;
    return !raw_h[x-2][i];
  endfunction

  // Level toggles once the synchronized level has disagreed with it for D un-reset cycles in a row
  task automatic model(input int c);
    for (int i = 0; i < 2; i++) begin
      if (rst_h[c]) begin
        mp[c][i] = 1'b0;
        rise_c[i] = -1;
        long_c[i] = -1;
        e_pr[i] = 1'b0; e_pp[i] = 1'b0; e_lp[i] = 1'b0; e_rp[i] = 1'b0;
      end else begin
        bit prev, tog, now;
        prev = (c > 0) ? mp[c-1][i] : 1'b0;
        tog  = 1'b1;
        for (int k = 1; k <= D; k++) begin
          if (c - k < 0) tog = 1'b0;
          else if (rst_h[c-k] || lvl(c - k, i) == prev) tog = 1'b0;
        end
        now = prev ^ tog;
        mp[c][i] = now;
        e_pr[i] = now;
        e_pp[i] = tog && now;
        e_rp[i] = tog && !now;
        if (tog && now) rise_c[i] = c;
        if (!now) begin
          rise_c[i] = -1;
          long_c[i] = -1;
        end
        e_lp[i] = now && (c - rise_c[i] + 1 == L);
        if (e_lp[i]) long_c[i] = c;
`ifdef KEY_AUTOREPEAT_EN
        if (now && long_c[i] >= 0 && c > long_c[i] && (c - long_c[i]) % R == 0) e_pp[i] = 1'b1;
`endif
      end
    end
  endtask

  task automatic sample();
    model(cyc);
    chk("pressed", pressed, e_pr);
    chk("press_pulse", press_pulse, e_pp);
    chk("long_pulse", long_pulse, e_lp);
    chk("release_pulse", release_pulse, e_rp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= N) begin
      $display("FAIL cycle_budget cycle=%0d limit=%0d", cyc, N);
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "cycle budget exhausted");
    end
    KEY = key_drv;
    rst = rst_drv;
    raw_h[cyc] = key_drv;
    rst_h[cyc] = rst_drv;
    #1;
    sample();
  endtask

  task automatic upto(input int rel);
    while (cyc < base + rel) tick();
  endtask

  initial begin
    logic [1:0] acc;
    int pp_q[$];
    int lp_q[$];
    int exp_pp[$];

    raw_h[0] = 2'b11;
    rst_h[0] = 1'b1;
    #2;
    sample();
    repeat (3) tick();
    chk("reset_pressed", pressed, 2'b00);
    chk("reset_press_pulse", press_pulse, 2'b00);
    rst_drv = 1'b0;
    repeat (10) tick();

    // Basic press and release on key 0
    base = cyc;
    upto(9);  key_drv[0] = 1'b0;
    upto(15); chk("basic_pressed_c15", pressed, 2'b00);
    upto(16); chk("basic_pressed_c16", pressed, 2'b01);
              chk("basic_pp_c16", press_pulse, 2'b01);
    upto(17); chk("basic_pp_c17", press_pulse, 2'b00);
    upto(29); key_drv[0] = 1'b1;
    upto(35); chk("basic_rp_c35", release_pulse, 2'b00);
    upto(36); chk("basic_rp_c36", release_pulse, 2'b01);
              chk("basic_pressed_c36", pressed, 2'b00);
    upto(37); chk("basic_rp_c37", release_pulse, 2'b00);
    upto(50);

    // Three-cycle glitch on key 1
    base = cyc;
    acc = 2'b00;
    upto(9);  key_drv[1] = 1'b0;
    upto(12); key_drv[1] = 1'b1;
    for (int rel = 13; rel <= 30; rel++) begin
      upto(rel);
      acc = acc | pressed | press_pulse | long_pulse | release_pulse;
    end
    chk("glitch_quiet", acc, 2'b00);

    // Long hold on key 0, released at cycle 48
    base = cyc;
    upto(9);  key_drv[0] = 1'b0;
    for (int rel = 10; rel <= 70; rel++) begin
      upto(rel);
      if (press_pulse[0]) pp_q.push_back(rel);
      if (long_pulse[0])  lp_q.push_back(rel);
      if (rel == 47) key_drv[0] = 1'b1;
    end
`ifdef KEY_AUTOREPEAT_EN
    exp_pp = '{16, 40, 45, 50};
`else
    exp_pp = '{16};
`endif
    chk_i("long_pp_count", pp_q.size(), exp_pp.size());
    for (int j = 0; j < exp_pp.size() && j < pp_q.size(); j++)
      chk_i("long_pp_cycle", pp_q[j], exp_pp[j]);
    chk_i("long_lp_count", lp_q.size(), 1);
    if (lp_q.size() > 0) chk_i("long_lp_cycle", lp_q[0], 35);
    upto(80);

    // Both keys together
    base = cyc;
    upto(9);  key_drv = 2'b00;
    upto(16); chk("simul_pp", press_pulse, 2'b11);
              chk("simul_pressed", pressed, 2'b11);
    upto(19); key_drv = 2'b11;
    upto(26); chk("simul_rp", release_pulse, 2'b11);
    upto(40);

    // Reset pulse at cycle 25 while key 0 held
    base = cyc;
    acc = 2'b00;
    upto(9);  key_drv[0] = 1'b0;
    upto(24); chk("rst_pre_pressed", pressed, 2'b01);
              rst_drv = 1'b1;
    upto(25); chk("rst_pressed", pressed, 2'b00);
              chk("rst_pp", press_pulse, 2'b00);
              acc = acc | release_pulse;
              rst_drv = 1'b0;
    for (int rel = 26; rel <= 36; rel++) begin
      upto(rel);
      acc = acc | release_pulse;
      if (rel == 31) chk("rst_pp_c31", press_pulse, 2'b00);
      if (rel == 32) chk("rst_pp_c32", press_pulse, 2'b01);
    end
    chk("rst_no_release", acc, 2'b00);
    upto(39); key_drv[0] = 1'b1;
    upto(60);

    // Random key levels with occasional reset pulses
    for (int s = 0; s < 60; s++) begin
      int len;
      key_drv = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 30);
      for (int j = 0; j < len; j++) tick();
      if ($urandom_range(0, 9) == 0) begin
        rst_drv = 1'b1;
        tick();
        rst_drv = 1'b0;
      end
    end
    key_drv = 2'b11;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
